// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared Wishbone bus bundles and arbiter state encoding.
//   wb_m2s_t : master-to-slave request (addr, data, sel, cyc, stb, we)
//   wb_s2m_t : slave-to-master response (ack, data)
//   state_t  : arbiter states, encoded so the state value is the one-hot grant
package wb_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        cyc;
        logic        stb;
        logic        we;
    } wb_m2s_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] data;
    } wb_s2m_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin Wishbone arbiter with per-transfer ack timeout.
//   i_clk     : clock, rising edge
//   i_rstn    : asynchronous active-low reset
//   i_wb_m0   : requester 0 (instruction fetch) request;  o_wb_m0 : its response
//   i_wb_m1   : requester 1 (load/store) request;         o_wb_m1 : its response
//   o_wb_s    : shared slave request;                     i_wb_s  : slave response
//   o_gnt     : one-hot grant (bit0 = m0, bit1 = m1, 00 = idle)
//   o_timeout : one-cycle pulse when a transfer is forcibly terminated
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  wb_m2s_t    i_wb_m0,
    output wb_s2m_t    o_wb_m0,
    input  wb_m2s_t    i_wb_m1,
    output wb_s2m_t    o_wb_m1,
    output wb_m2s_t    o_wb_s,
    input  wb_s2m_t    i_wb_s,
    output logic [1:0] o_gnt,
    output logic       o_timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    state_t     state, state_next;
    logic       last, last_next;
    logic [7:0] cnt, cnt_next;
    wb_m2s_t    req;
    wb_s2m_t    fwd;
    logic       expired;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs are decoded from state, so reset drops the slave bus and grant
    // immediately without waiting for a clock.
    always_comb begin
        req        = (state == GNT0) ? i_wb_m0 : (state == GNT1) ? i_wb_m1 : '0;
        // A real ack always wins over an expiring counter; an abort (cyc low) never times out.
        expired    = (state != IDLE) && req.cyc && !i_wb_s.ack && (cnt == LIMIT);
        o_wb_s     = req;
        o_wb_s.cyc = req.cyc & ~expired;
        o_wb_s.stb = req.stb & ~expired;
        fwd        = expired ? '{ack: 1'b1, data: 32'h0} : i_wb_s;
        o_wb_m0    = (state == GNT0) ? fwd : '0;
        o_wb_m1    = (state == GNT1) ? fwd : '0;
        o_gnt      = state;
        o_timeout  = expired;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = (i_wb_m0.cyc && i_wb_m1.cyc) ? (last ? GNT0 : GNT1) :
                         i_wb_m0.cyc ? GNT0 :
                         i_wb_m1.cyc ? GNT1 : IDLE;
        else if (!req.cyc || expired)
            state_next = IDLE;
        last_next = (state == IDLE && state_next == GNT0) ? 1'b0 :
                    (state == IDLE && state_next == GNT1) ? 1'b1 : last;
        cnt_next  = (state_next != state || i_wb_s.ack) ? 8'd0 :
                    (state != IDLE && req.stb) ? cnt + 8'd1 : cnt;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter (vector table, directed corners, random vs model).
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    wb_m2s_t    m0, m1, s_req;
    wb_s2m_t    s_rsp, m0_rsp, m1_rsp;
    logic [1:0] gnt;
    logic       tmo;
    int         vecs = 0;
    int         errs = 0;

    wb_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_wb_m0(m0), .o_wb_m0(m0_rsp),
        .i_wb_m1(m1), .o_wb_m1(m1_rsp),
        .o_wb_s(s_req), .i_wb_s(s_rsp),
        .o_gnt(gnt), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        c0, c1, ack;
        logic [31:0] sd;
        logic [1:0]  gnt;
        logic        scyc;
        logic [31:0] saddr;
        logic        a0, a1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c0, logic c1, logic ack, logic [31:0] sd, logic [1:0] g,
                                logic scyc, logic [31:0] saddr, logic a0, logic a1,
                                logic [31:0] d0, logic [31:0] d1);
        vec_t v;
        v = '{c0: c0, c1: c1, ack: ack, sd: sd, gnt: g, scyc: scyc, saddr: saddr,
              a0: a0, a1: a1, d0: d0, d1: d1};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0 = '{addr: 32'h100, data: 32'h0, sel: 4'hf, cyc: 1'b0, stb: 1'b0, we: 1'b0};
        m1 = '{addr: 32'h200, data: 32'h22, sel: 4'h3, cyc: 1'b0, stb: 1'b0, we: 1'b1};
        s_rsp = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rstn = 1'b0;
        adv();
        adv();
        rstn = 1'b1;
    endtask

    // Reference model: owner (-1 idle, 0, 1), wait count, last winner.
    int      own, wc, lst;
    wb_m2s_t req_m, e_s;
    wb_s2m_t e_r, e_m0, e_m1;
    logic    to_m;
    logic [1:0] e_gnt;

    task automatic predict;
        req_m = own == 0 ? m0 : own == 1 ? m1 : '0;
        to_m  = own >= 0 && req_m.cyc && !s_rsp.ack && wc == TO;
        e_s   = req_m;
        if (to_m) begin
            e_s.cyc = 1'b0;
            e_s.stb = 1'b0;
        end
        e_r = s_rsp;
        if (to_m) e_r = '{ack: 1'b1, data: 32'h0};
        e_m0  = own == 0 ? e_r : '0;
        e_m1  = own == 1 ? e_r : '0;
        e_gnt = own < 0 ? 2'b00 : 2'(1 << own);
    endtask

    task automatic model_step;
        if (own < 0) begin
            own = (m0.cyc && m1.cyc) ? 1 - lst : m0.cyc ? 0 : m1.cyc ? 1 : -1;
            if (own >= 0) begin
                lst = own;
                wc  = 0;
            end
        end else if (!req_m.cyc || to_m) begin
            own = -1;
            wc  = 0;
        end else if (s_rsp.ack) wc = 0;
        else if (req_m.stb) wc++;
    endtask

    initial begin
        idle_inputs();
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        s_rsp = '{ack: 1'b1, data: 32'hDEAD};
        @(negedge clk);
        chk("reset", 160'({gnt, tmo, s_req, m0_rsp, m1_rsp}), 160'(0));
        do_reset();

        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'hD0000001, 2'b01, 1, 32'h100, 1, 0, 32'hD0000001, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'b01, 0, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'hD0000002, 2'b10, 1, 32'h200, 0, 1, 0, 32'hD0000002));
        tbl.push_back(mk(1, 0, 0, 0, 2'b10, 0, 32'h200, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'hD0000003, 2'b01, 1, 32'h100, 1, 0, 32'hD0000003, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'b01, 0, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'hD0000004, 2'b10, 1, 32'h200, 0, 1, 0, 32'hD0000004));
        tbl.push_back(mk(1, 0, 0, 0, 2'b10, 0, 32'h200, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'hD0000005, 2'b01, 1, 32'h100, 1, 0, 32'hD0000005, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'b01, 0, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'hD0000006, 2'b10, 1, 32'h200, 0, 1, 0, 32'hD0000006));
        tbl.push_back(mk(1, 0, 0, 0, 2'b10, 0, 32'h200, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            m0.cyc = tbl[i].c0;
            m0.stb = tbl[i].c0;
            m1.cyc = tbl[i].c1;
            m1.stb = tbl[i].c1;
            s_rsp  = '{ack: tbl[i].ack, data: tbl[i].sd};
            @(negedge clk);
            chk($sformatf("tbl[%0d]", i),
                160'({gnt, tmo, s_req.cyc, s_req.addr, m0_rsp.ack, m0_rsp.data, m1_rsp.ack, m1_rsp.data}),
                160'({tbl[i].gnt, 1'b0, tbl[i].scyc, tbl[i].saddr, tbl[i].a0, tbl[i].d0,
                      tbl[i].a1, tbl[i].d1}));
            adv();
        end

        // m0 read, slave acks after 3 wait cycles
        do_reset();
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        adv();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rd wait", 160'({gnt, s_req.cyc, s_req.addr, m0_rsp.ack}), 160'({2'b01, 1'b1, 32'h100, 1'b0}));
            adv();
        end
        s_rsp = '{ack: 1'b1, data: 32'hCAFE0001};
        @(negedge clk);
        chk("rd ack", 160'({gnt, tmo, m0_rsp, m1_rsp}), 160'({2'b01, 1'b0, 1'b1, 32'hCAFE0001, 33'h0}));
        adv();
        idle_inputs();
        adv();
        adv();

        // m1 write never acked: timeout, then a late ack is dropped
        m1.cyc = 1'b1;
        m1.stb = 1'b1;
        adv();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("to wait", 160'({gnt, tmo, s_req.cyc, m1_rsp.ack}), 160'({2'b10, 1'b0, 1'b1, 1'b0}));
            adv();
        end
        @(negedge clk);
        chk("to fire", 160'({gnt, tmo, s_req.cyc, s_req.stb, m1_rsp}), 160'({2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0}));
        adv();
        m1.cyc = 1'b0;
        m1.stb = 1'b0;
        @(negedge clk);
        chk("to once", 160'({gnt, tmo}), 160'({2'b00, 1'b0}));
        adv();
        s_rsp = '{ack: 1'b1, data: 32'hBAD0BAD0};
        @(negedge clk);
        chk("late ack", 160'({gnt, m0_rsp, m1_rsp}), 160'(0));
        adv();
        idle_inputs();
        adv();

        // ack arriving exactly at the limit wins over the timeout
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        adv();
        for (int k = 0; k < TO; k++) adv();
        s_rsp = '{ack: 1'b1, data: 32'h55};
        @(negedge clk);
        chk("ack at limit", 160'({gnt, tmo, s_req.cyc, m0_rsp}), 160'({2'b01, 1'b0, 1'b1, 1'b1, 32'h55}));
        adv();
        idle_inputs();
        adv();
        adv();

        // asynchronous reset while m1 holds a pending strobe
        m1.cyc = 1'b1;
        m1.stb = 1'b1;
        adv();
        adv();
        chk("pre rst", 160'({gnt, s_req.cyc}), 160'({2'b10, 1'b1}));
        #2;
        rstn = 1'b0;
        #1;
        chk("async rst", 160'({gnt, s_req.cyc, s_req.stb}), 160'(0));
        adv();
        rstn = 1'b1;
        @(negedge clk);
        chk("post rst idle", 160'({gnt, s_req.cyc}), 160'(0));
        adv();
        @(negedge clk);
        chk("post rst regrant", 160'({gnt, s_req.cyc}), 160'({2'b10, 1'b1}));

        // randomized traffic against the reference model
        do_reset();
        own = -1;
        wc  = 0;
        lst = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) m0.cyc = ~m0.cyc;
            if ($urandom_range(3) == 0) m1.cyc = ~m1.cyc;
            m0.stb  = m0.cyc & ($urandom_range(3) != 0);
            m1.stb  = m1.cyc & ($urandom_range(3) != 0);
            m0.addr = $urandom;
            m0.data = $urandom;
            m0.sel  = 4'($urandom_range(15));
            m0.we   = 1'($urandom_range(1));
            m1.addr = $urandom;
            m1.data = $urandom;
            m1.sel  = 4'($urandom_range(15));
            m1.we   = 1'($urandom_range(1));
            s_rsp   = '{ack: ($urandom_range(5) == 0), data: $urandom};
            @(negedge clk);
            predict();
            chk($sformatf("rand[%0d]", n), 160'({gnt, tmo, s_req, m0_rsp, m1_rsp}),
                160'({e_gnt, to_m, e_s, e_m0, e_m1}));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
